// File: rtl/stage_if_pkg.sv
// Shared types and constants for the multithreaded fetch stage.
package stage_if_pkg;

    localparam int N_THREADS = 4;
    localparam int TID_W     = $clog2(N_THREADS);

    typedef logic [TID_W-1:0] threadid_t;
    typedef logic [31:0]      vptr_t;
    typedef logic [31:0]      word_t;

    localparam vptr_t RESET_PC = 32'h0000_1000;
    localparam word_t NOP_WORD = 32'h0000_0000;

    typedef struct packed {
        logic      valid;
        threadid_t thread;
    } fetch_sel_t;

    // Thread count is a power of two, so the natural wrap of threadid_t is modulo N_THREADS.
    function automatic threadid_t next_tid(input threadid_t t);
        return t + threadid_t'(1);
    endfunction

endpackage

// File: rtl/stage_if_if.sv
// Fetch-stage bus bundle: I-cache/ITLB lookup, refill, redirects, rm4 and the IFID payload.
interface stage_if_if;
    import stage_if_pkg::*;

    logic                             o_ic_req;
    vptr_t                            o_ic_addr;
    threadid_t                        o_ic_thread;
    logic                             i_ic_hit;
    word_t                            i_ic_data;
    logic                             i_itlb_miss;
    logic                             i_ic_fill_valid;
    threadid_t                        i_ic_fill_thread;
    logic                             i_ex_redirect_en;
    threadid_t                        i_ex_redirect_thread;
    vptr_t                            i_ex_redirect_pc;
    logic                             i_wb_redirect_en;
    threadid_t                        i_wb_redirect_thread;
    vptr_t                            i_wb_redirect_pc;
    logic [N_THREADS-1:0][31:0]       i_rm4;
    vptr_t                            o_if_pc;
    word_t                            o_if_instruction;
    threadid_t                        o_if_thread;
    logic                             o_if_itlb_miss;
    logic                             o_if_icache_miss;
    word_t                            o_if_rm4;

    modport master (
        output o_ic_req, o_ic_addr, o_ic_thread,
        input  i_ic_hit, i_ic_data, i_itlb_miss,
        input  i_ic_fill_valid, i_ic_fill_thread,
        input  i_ex_redirect_en, i_ex_redirect_thread, i_ex_redirect_pc,
        input  i_wb_redirect_en, i_wb_redirect_thread, i_wb_redirect_pc,
        input  i_rm4,
        output o_if_pc, o_if_instruction, o_if_thread,
        output o_if_itlb_miss, o_if_icache_miss, o_if_rm4
    );

    modport slave (
        input  o_ic_req, o_ic_addr, o_ic_thread,
        output i_ic_hit, i_ic_data, i_itlb_miss,
        output i_ic_fill_valid, i_ic_fill_thread,
        output i_ex_redirect_en, i_ex_redirect_thread, i_ex_redirect_pc,
        output i_wb_redirect_en, i_wb_redirect_thread, i_wb_redirect_pc,
        output i_rm4,
        input  o_if_pc, o_if_instruction, o_if_thread,
        input  o_if_itlb_miss, o_if_icache_miss, o_if_rm4
    );

endinterface

// File: rtl/stage_if_rr_arbiter.sv
// Round-robin thread picker. STAGE_IF_SKIP_PARKED_EN: scan past ineligible threads;
// otherwise strictly take rr_last+1 and report it invalid when it is not eligible.
module stage_if_rr_arbiter
    import stage_if_pkg::*;
(
    input  logic [N_THREADS-1:0] i_eligible,
    input  threadid_t            i_rr_last,
    output fetch_sel_t           o_sel
);

    fetch_sel_t w_sel;

`ifdef STAGE_IF_SKIP_PARKED_EN
    threadid_t w_cand;

    // Descending scan so the closest eligible thread after rr_last is the last one written.
    always_comb begin
        w_sel.valid  = 1'b0;
        w_sel.thread = next_tid(i_rr_last);
        w_cand       = '0;
        for (int k = N_THREADS; k >= 1; k--) begin
            w_cand = threadid_t'(32'(i_rr_last) + 32'(k));
            if (i_eligible[w_cand]) begin
                w_sel.valid  = 1'b1;
                w_sel.thread = w_cand;
            end
        end
    end
`else
    always_comb begin
        w_sel.thread = next_tid(i_rr_last);
        w_sel.valid  = i_eligible[w_sel.thread];
    end
`endif

    assign o_sel = w_sel;

endmodule

// File: rtl/stage_if.sv
// Multithreaded instruction fetch feeding the IFID register; park-on-miss, EX/WB redirects.
// STAGE_IF_SKIP_PARKED_EN selects skip-parked arbitration instead of strict round-robin.
module stage_if
    import stage_if_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    stage_if_if.master    bus
);

    vptr_t                r_pc [N_THREADS];
    logic [N_THREADS-1:0] r_parked;
    threadid_t            r_rr_last;

    fetch_sel_t           w_sel;
    logic                 w_adv;
    logic                 w_park;

    stage_if_rr_arbiter u_arb (
        .i_eligible (~r_parked),
        .i_rr_last  (r_rr_last),
        .o_sel      (w_sel)
    );

    assign bus.o_ic_req    = w_sel.valid;
    assign bus.o_ic_addr   = r_pc[w_sel.thread];
    assign bus.o_ic_thread = w_sel.thread;

    // An ITLB miss suppresses both the advance and the park; the WB redirect recovers it.
    assign w_adv  = w_sel.valid &  bus.i_ic_hit & ~bus.i_itlb_miss;
    assign w_park = w_sel.valid & ~bus.i_ic_hit & ~bus.i_itlb_miss;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int t = 0; t < N_THREADS; t++) begin
                r_pc[t] <= RESET_PC;
            end
            r_parked             <= '0;
            r_rr_last            <= threadid_t'(N_THREADS - 1);
            bus.o_if_pc          <= '0;
            bus.o_if_instruction <= NOP_WORD;
            bus.o_if_thread      <= '0;
            bus.o_if_rm4         <= '0;
            bus.o_if_itlb_miss   <= 1'b0;
            bus.o_if_icache_miss <= 1'b1;
        end else begin
`ifdef STAGE_IF_SKIP_PARKED_EN
            if (w_sel.valid) begin
                r_rr_last <= w_sel.thread;
            end
`else
            r_rr_last <= w_sel.thread;
`endif
            // Later assignments win: fill beats park, EX beats sequential, WB beats EX.
            for (int t = 0; t < N_THREADS; t++) begin
                if (w_adv && w_sel.thread == threadid_t'(t)) begin
                    r_pc[t] <= r_pc[t] + 32'd4;
                end
                if (w_park && w_sel.thread == threadid_t'(t)) begin
                    r_parked[t] <= 1'b1;
                end
                if (bus.i_ic_fill_valid && bus.i_ic_fill_thread == threadid_t'(t)) begin
                    r_parked[t] <= 1'b0;
                end
                if (bus.i_ex_redirect_en && bus.i_ex_redirect_thread == threadid_t'(t)) begin
                    r_pc[t]     <= bus.i_ex_redirect_pc;
                    r_parked[t] <= 1'b0;
                end
                if (bus.i_wb_redirect_en && bus.i_wb_redirect_thread == threadid_t'(t)) begin
                    r_pc[t]     <= bus.i_wb_redirect_pc;
                    r_parked[t] <= 1'b0;
                end
            end

            bus.o_if_pc          <= r_pc[w_sel.thread];
            bus.o_if_thread      <= w_sel.thread;
            bus.o_if_rm4         <= bus.i_rm4[w_sel.thread];
            bus.o_if_instruction <= w_adv ? bus.i_ic_data : NOP_WORD;
            bus.o_if_itlb_miss   <= w_sel.valid & bus.i_itlb_miss;
            bus.o_if_icache_miss <= ~w_sel.valid | w_park;
        end
    end

endmodule

// File: doc/stage_if.md
# stage_if

Multithreaded instruction-fetch stage, directly upstream of the decode stage; it drives the IFID pipeline register that decode consumes. Holds one PC per hardware thread and picks a thread round-robin each cycle. Performs a same-cycle lookup in the instruction cache and ITLB, and registers the instruction plus miss flags into IFID. Parks threads on I-cache misses until refill, and applies branch and exception redirects from EX and WB.

## Interface
- N_THREADS, common::n_threads (4): hardware threads; power of two.
- RESET_PC, 32'h0000_1000: boot PC of every thread.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- ic_req  out  1  lookup valid this cycle.
- ic_addr  out  vptr_t  fetch virtual address.
- ic_thread  out  threadid_t  thread issuing the lookup.
- ic_hit  in  1  same-cycle cache hit for ic_addr.
- ic_data  in  word_t  instruction word; valid when ic_hit.
- itlb_miss  in  1  same-cycle ITLB miss for ic_addr.
- ic_fill_valid  in  1  refill for ic_fill_thread completed.
- ic_fill_thread  in  threadid_t  thread whose miss was refilled.
- ex_redirect_en / ex_redirect_thread / ex_redirect_pc  in  1 / threadid_t / vptr_t  taken branch or jump.
- wb_redirect_en / wb_redirect_thread / wb_redirect_pc  in  1 / threadid_t / vptr_t  exception entry or iret.
- rm4  in  word_t[N_THREADS]  per-thread rm4 special register.
- if_pc, if_instruction, if_thread  out  vptr_t, word_t, threadid_t  IFID payload.
- if_itlb_miss, if_icache_miss  out  1 each  IFID miss flags; icache_miss=1 marks a bubble.
- if_rm4  out  word_t  rm4 of the fetched thread.

## Operation
- State: pc[N_THREADS], parked[N_THREADS], rr_last (threadid_t).
- Select: the first eligible thread scanning from rr_last+1, wrapping modulo N_THREADS. Eligible means not parked.
- If no thread is eligible, the cycle is a bubble:
  - ic_req=0.
  - IFID receives if_icache_miss=1, if_itlb_miss=0, if_instruction=0, if_thread=rr_last+1.
  - rr_last is unchanged.
- On a real selection: ic_req=1, ic_addr=pc[sel], ic_thread=sel, and rr_last<=sel.
- Hit without ITLB miss: the instruction passes to IFID and pc[sel] advances by 4 (32-bit wrap, no overflow flag).
- ITLB miss: if_itlb_miss=1 and pc[sel] is held. No park; downstream raises the exception, which returns as a WB redirect.
- Cache miss without ITLB miss: if_icache_miss=1, pc[sel] is held, and parked[sel]<=1.
- ITLB miss takes priority: no park.
- ic_fill_valid clears parked[ic_fill_thread] on the same edge.
- Redirects set pc[t]<=redirect_pc and clear parked[t]. Priority on the same thread: WB over EX over sequential update or park.
- The EX and WB redirects act independently when they target different threads.
- An instruction fetched from a thread being redirected in the same cycle is still emitted. Downstream invalidation discards it.
- if_rm4 <= rm4[selected thread].

## Timing
- Select and ic_addr are combinational from registered state. All IFID outputs are registered and appear one edge after the lookup.
- A parked thread becomes eligible the cycle after the edge that samples ic_fill_valid.
- A redirected PC is fetched at the earliest in the cycle after the redirect edge.
- Reset (asynchronous, takes effect mid-operation as well):
  - pc[t]=RESET_PC, parked=0, rr_last=N_THREADS-1, so thread 0 is fetched first.
  - if_pc=0, if_instruction=0, if_thread=0, if_rm4=0, if_itlb_miss=0, if_icache_miss=1.
- A fill and a redirect to the same thread on the same edge both clear the park, and the redirect PC wins.

## Configuration
- STAGE_IF_SKIP_PARKED_EN defined: selection skips parked threads as described above.
- Not defined: strict round-robin, rr_last<=rr_last+1 every cycle.
  - A parked selected thread yields a bubble with ic_req=0.
  - Park, fill and redirect rules are unchanged.

## Structure
- Add to common: fetch_sel_t (valid + threadid_t) and constants RESET_PC and NOP_WORD = 0.
- One sub-module, rr_arbiter: N_THREADS-wide eligibility mask plus rr_last in; valid plus selected thread out.

## Test plan
- Reset, 4 threads, all hits -> IFID threads 0,1,2,3,0; each thread's if_pc steps 0x1000, 0x1004.
- Thread 1 misses at 0x1000 -> if_icache_miss=1, thread 1 skipped (0,2,3,0…); fill for thread 1 -> thread 1 refetches 0x1000 two cycles later.
- ITLB miss on thread 2 -> if_itlb_miss=1, pc[2] held at 0x1000, no park; next turn refetches 0x1000.
- Same cycle: EX redirect thread 0 to 0x2000 and WB redirect thread 0 to 0x3000 -> thread 0 next fetches 0x3000.
- All four threads parked -> bubbles with ic_req=0 and if_icache_miss=1 until the first fill.
- Assert rst mid-stream while thread 3 is parked -> all PCs 0x1000, parked cleared, first fetch thread 0.
